// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcodes, flag indices and default width for the ALU accumulator pipe
//
// Purpose : common definitions imported by the interface, the adder and the top.
// Contents: DEFAULT_WIDTH, FLAG_* bit positions within {N,Z,C,V}, opcode_t enum.
// Build   : the optional ALU_SAT_EN macro is consumed by alu_accum_pipe, not here.

package alu_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Positions inside the 4-bit flag word {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_ADC   = 4'd2,
        OP_SBB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NAND  = 4'd7,
        OP_NOR   = 4'd8,
        OP_NOT   = 4'd9,
        OP_SHL   = 4'd10,
        OP_SHR   = 4'd11,
        OP_PASSB = 4'd12,
        OP_CLRC  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } opcode_t;

endpackage

// File: rtl/alu_accum_pipe_if.sv
// rtl/alu_accum_pipe_if.sv - operation/result handshake bundle for alu_accum_pipe
//
// Purpose : groups the request side (in_*), the result side (out_*) and the
//           accumulator view into one bundle.
// Modports: master - the producer/consumer around the pipe (drives in_*, out_ready)
//           slave  - the pipe itself (drives in_ready, out_*, acc_value)
// Signals : in_valid/in_ready/in_op/in_a/in_b/in_use_acc/in_acc_wr,
//           out_valid/out_ready/out_result/out_flags {N,Z,C,V}, acc_value.

interface alu_accum_pipe_if
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_use_acc;
    logic             in_acc_wr;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;

    logic [WIDTH-1:0] acc_value;

    modport master (
        output in_valid, in_op, in_a, in_b, in_use_acc, in_acc_wr, out_ready,
        input  in_ready, out_valid, out_result, out_flags, acc_value
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_use_acc, in_acc_wr, out_ready,
        output in_ready, out_valid, out_result, out_flags, acc_value
    );

endinterface

// File: rtl/alu_prefix_adder.sv
// rtl/alu_prefix_adder.sv - parameterised Kogge-Stone adder with carry-in and carry-out
//
// Purpose : a + b + cin over WIDTH bits using a log2(WIDTH)-level parallel prefix tree.
// Ports   : a, b  [WIDTH-1:0] operands
//           cin                carry into bit 0
//           sum   [WIDTH-1:0]  truncated sum
//           cout               carry out of the MSB (bit WIDTH of the full sum)

module alu_prefix_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    // Level k holds group generate/propagate spanning 2^k bits ending at each bit.
    logic [WIDTH-1:0] g_l [0:LEVELS];
    logic [WIDTH-1:0] p_l [0:LEVELS];

    // Folding cin into bit 0's generate makes every prefix G[i] the true carry
    // out of bit i, so no separate carry-in level is needed.
    assign p_l[0] = a ^ b;
    assign g_l[0] = (a & b) | {{(WIDTH-1){1'b0}}, (a[0] ^ b[0]) & cin};

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_node
                assign g_l[l+1][i] = g_l[l][i] | (p_l[l][i] & g_l[l][i-(1<<l)]);
                assign p_l[l+1][i] = p_l[l][i] & p_l[l][i-(1<<l)];
            end else begin : g_pass
                assign g_l[l+1][i] = g_l[l][i];
                assign p_l[l+1][i] = p_l[l][i];
            end
        end
    end

    assign sum  = p_l[0] ^ {g_l[LEVELS][WIDTH-2:0], cin};
    assign cout = g_l[LEVELS][WIDTH-1];

endmodule

// File: rtl/alu_accum_pipe.sv
// rtl/alu_accum_pipe.sv - two-stage valid/ready ALU with accumulator and stored carry
//
// Purpose : stage 1 registers an accepted operation; stage 2 computes the
//           result and {N,Z,C,V} flags, and reads/writes the accumulator and
//           stored carry at the stage 1->2 advance so dependent back-to-back
//           operations need no stall. Latency 2 cycles, one op per cycle.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - alu_accum_pipe_if.slave (in_*, out_*, acc_value)
// Params  : WIDTH  - operand/result/accumulator width, 4..32
// Options : ALU_SAT_EN - when defined, ADD/ADC saturate to all-ones on carry
//           and SUB/SBB saturate to zero on borrow; C and V still describe the
//           unsaturated result. Undefined (default): all arithmetic wraps.

module alu_accum_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_accum_pipe_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             s1_valid;
    opcode_t          s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_use_acc;
    logic             s1_acc_wr;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [3:0]       out_flags_q;

    logic [WIDTH-1:0] acc_q;
    logic             carry_q;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s2_advance;

    assign s2_advance   = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_advance;

    // ------------------------------------------------------------------
    // Stage 2 datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             is_sub;
    logic             arith_c;
    logic             arith_v;

    always_comb begin
        a_eff  = s1_use_acc ? acc_q : s1_a;
        is_sub = (s1_op == OP_SUB) || (s1_op == OP_SBB);
        // Subtraction as a + ~b + cin: cin=1 for SUB, cin=!borrow for SBB.
        add_b  = is_sub ? ~s1_b : s1_b;
        case (s1_op)
            OP_ADC:  add_cin = carry_q;
            OP_SUB:  add_cin = 1'b1;
            OP_SBB:  add_cin = ~carry_q;
            default: add_cin = 1'b0;
        endcase
    end

    alu_prefix_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (a_eff),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Borrow is the inverted carry of the a + ~b form.
    assign arith_c = is_sub ? ~add_cout : add_cout;
    // Signed overflow: both addends share a sign that the sum does not.
    assign arith_v = (a_eff[WIDTH-1] == add_b[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != a_eff[WIDTH-1]);

    logic [WIDTH-1:0] alu_res;
    logic             new_c;
    logic             new_v;
    logic             res_wr_ok;
    logic [3:0]       res_flags;

    always_comb begin
        alu_res   = '0;
        new_c     = carry_q;
        new_v     = 1'b0;
        res_wr_ok = 1'b1;
        case (s1_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                alu_res = add_sum;
                new_c   = arith_c;
                new_v   = arith_v;
`ifdef ALU_SAT_EN
                if (arith_c) begin
                    alu_res = is_sub ? '0 : '1;
                end
`endif
            end
            OP_AND:   alu_res = a_eff & s1_b;
            OP_OR:    alu_res = a_eff | s1_b;
            OP_XOR:   alu_res = a_eff ^ s1_b;
            OP_NAND:  alu_res = ~(a_eff & s1_b);
            OP_NOR:   alu_res = ~(a_eff | s1_b);
            OP_NOT:   alu_res = ~a_eff;
            OP_SHL: begin
                alu_res = {a_eff[WIDTH-2:0], 1'b0};
                new_c   = a_eff[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_eff[WIDTH-1:1]};
                new_c   = a_eff[0];
            end
            OP_PASSB: alu_res = s1_b;
            OP_CLRC: begin
                alu_res = a_eff;
                new_c   = 1'b0;
            end
            default: begin
                // Reserved opcodes: zero result, no accumulator write,
                // carry kept; the op still produces an output beat.
                alu_res   = '0;
                res_wr_ok = 1'b0;
            end
        endcase

        res_flags         = '0;
        res_flags[FLAG_N] = alu_res[WIDTH-1];
        res_flags[FLAG_Z] = (alu_res == '0);
        res_flags[FLAG_C] = new_c;
        res_flags[FLAG_V] = new_v;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_op        <= OP_ADD;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_use_acc   <= 1'b0;
            s1_acc_wr    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            // Stage 1 refills whenever it is empty or draining this cycle.
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op      <= opcode_t'(bus.in_op);
                    s1_a       <= bus.in_a;
                    s1_b       <= bus.in_b;
                    s1_use_acc <= bus.in_use_acc;
                    s1_acc_wr  <= bus.in_acc_wr;
                end
            end

            // Accumulator and carry commit at the same edge the result is
            // registered, so the next op in stage 1 already sees them.
            if (s2_advance) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_result_q <= alu_res;
                    out_flags_q  <= res_flags;
                    carry_q      <= new_c;
                    if (s1_acc_wr && res_wr_ok) begin
                        acc_q <= alu_res;
                    end
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
    assign bus.acc_value  = acc_q;

endmodule

// File: tb/tb_alu_accum_pipe.sv
// tb/tb_alu_accum_pipe.sv - directed table-driven bench for alu_accum_pipe (WIDTH=8)

module tb_alu_accum_pipe;
    import alu_pipe_pkg::*;

    localparam int W = 8;

`ifdef ALU_SAT_EN
    localparam logic [7:0] R_ADD_F0_20 = 8'hFF;
    localparam logic [3:0] F_ADD_F0_20 = 4'b1010;
    localparam logic [7:0] R_ADD_FF_01 = 8'hFF;
    localparam logic [3:0] F_ADD_FF_01 = 4'b1010;
    localparam logic [7:0] R_SUB_10_20 = 8'h00;
    localparam logic [3:0] F_SUB_10_20 = 4'b0110;
`else
    localparam logic [7:0] R_ADD_F0_20 = 8'h10;
    localparam logic [3:0] F_ADD_F0_20 = 4'b0010;
    localparam logic [7:0] R_ADD_FF_01 = 8'h00;
    localparam logic [3:0] F_ADD_FF_01 = 4'b0110;
    localparam logic [7:0] R_SUB_10_20 = 8'hF0;
    localparam logic [3:0] F_SUB_10_20 = 4'b1010;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_accum_pipe_if #(.WIDTH(W)) bus ();

    alu_accum_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Every output transfer is captured as {flags, result}.
    logic [11:0] out_q [$];
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready)
            out_q.push_back({bus.out_flags, bus.out_result});
    end

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input logic aw);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_use_acc = ua;
        bus.in_acc_wr  = aw;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_op      = 4'hF;
        bus.in_a       = 8'hA5;
        bus.in_b       = 8'h5A;
        bus.in_use_acc = 1'b1;
        bus.in_acc_wr  = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic aw);
        bit done = 1'b0;
        drive(op, a, b, ua, aw);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        idle();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready 0 required 1");
        end
    endtask

    task automatic get(output logic [11:0] v, input string name);
        int n = 0;
        while (out_q.size() == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual no out_valid required out_valid", name);
            v = 12'hFFF;
        end else begin
            v = out_q.pop_front();
        end
    endtask

    task automatic lat_test(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
        logic [11:0] v;
        drive(op, a, b, 1'b0, 1'b0);
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check({tag, "_valid_cycle1"}, bus.out_valid, 0);
        @(negedge clk);
        check({tag, "_valid_cycle2"}, bus.out_valid, 1);
        @(posedge clk);
        #1;
        get(v, tag);
        check({tag, "_result"}, v[7:0], er);
        check({tag, "_flags"}, v[11:8], ef);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ua;
        logic       aw;
        logic [7:0] er;
        logic [3:0] ef;
        logic [7:0] ea;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic ua, input logic aw, input logic [7:0] er,
                                input logic [3:0] ef, input logic [7:0] ea);
        vec_t r;
        r.op = op; r.a = a; r.b = b; r.ua = ua; r.aw = aw;
        r.er = er; r.ef = ef; r.ea = ea;
        return r;
    endfunction

    vec_t vecs [$];

    initial begin
        logic [11:0] v;
        logic [3:0]  sop [3];
        logic [7:0]  sa  [3];
        logic [7:0]  sb  [3];
        logic [7:0]  ser [3];
        logic [3:0]  sef [3];
        int          idx;
        bit          hs;

        // Rows run in order; carry and accumulator flow from row to row.
        vecs.push_back(mk(OP_ADD,   8'hF0, 8'h20, 0, 0, R_ADD_F0_20, F_ADD_F0_20, 8'h00));
        vecs.push_back(mk(OP_ADD,   8'hFF, 8'h01, 0, 0, R_ADD_FF_01, F_ADD_FF_01, 8'h00));
        vecs.push_back(mk(OP_ADC,   8'h00, 8'h00, 0, 0, 8'h01, 4'b0000, 8'h00));
        vecs.push_back(mk(OP_SUB,   8'h10, 8'h20, 0, 0, R_SUB_10_20, F_SUB_10_20, 8'h00));
        vecs.push_back(mk(OP_SBB,   8'h05, 8'h02, 0, 0, 8'h02, 4'b0000, 8'h00));
        vecs.push_back(mk(OP_ADD,   8'h7F, 8'h01, 0, 0, 8'h80, 4'b1001, 8'h00));
        vecs.push_back(mk(OP_SUB,   8'h80, 8'h01, 0, 0, 8'h7F, 4'b0001, 8'h00));
        vecs.push_back(mk(OP_AND,   8'hF0, 8'h3C, 0, 0, 8'h30, 4'b0000, 8'h00));
        vecs.push_back(mk(OP_OR,    8'h0F, 8'h30, 0, 0, 8'h3F, 4'b0000, 8'h00));
        vecs.push_back(mk(OP_XOR,   8'hFF, 8'h0F, 0, 0, 8'hF0, 4'b1000, 8'h00));
        vecs.push_back(mk(OP_NAND,  8'hFF, 8'hFF, 0, 0, 8'h00, 4'b0100, 8'h00));
        vecs.push_back(mk(OP_NOR,   8'h00, 8'h00, 0, 0, 8'hFF, 4'b1000, 8'h00));
        vecs.push_back(mk(OP_NOT,   8'h55, 8'h00, 0, 0, 8'hAA, 4'b1000, 8'h00));
        vecs.push_back(mk(OP_SHL,   8'h81, 8'h00, 0, 0, 8'h02, 4'b0010, 8'h00));
        vecs.push_back(mk(OP_AND,   8'hFF, 8'h80, 0, 0, 8'h80, 4'b1010, 8'h00));
        vecs.push_back(mk(OP_SHR,   8'h01, 8'h00, 0, 0, 8'h00, 4'b0110, 8'h00));
        vecs.push_back(mk(OP_CLRC,  8'hC3, 8'h00, 0, 0, 8'hC3, 4'b1000, 8'h00));
        vecs.push_back(mk(OP_PASSB, 8'h00, 8'h80, 0, 0, 8'h80, 4'b1000, 8'h00));
        vecs.push_back(mk(OP_PASSB, 8'h00, 8'h5A, 0, 1, 8'h5A, 4'b0000, 8'h5A));
        vecs.push_back(mk(OP_RSV14, 8'h12, 8'h34, 0, 1, 8'h00, 4'b0100, 8'h5A));
        vecs.push_back(mk(OP_RSV15, 8'hFF, 8'hFF, 0, 1, 8'h00, 4'b0100, 8'h5A));
        vecs.push_back(mk(OP_PASSB, 8'h00, 8'h05, 0, 1, 8'h05, 4'b0000, 8'h05));
        vecs.push_back(mk(OP_ADD,   8'hEE, 8'h03, 1, 1, 8'h08, 4'b0000, 8'h08));

        idle();
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_flags", bus.out_flags, 0);
        check("rst_acc_value", bus.acc_value, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_test("latency", OP_ADD, 8'hF0, 8'h20, R_ADD_F0_20, F_ADD_F0_20);

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].aw);
            get(v, $sformatf("row%0d", i));
            check($sformatf("row%0d_result", i), v[7:0], vecs[i].er);
            check($sformatf("row%0d_flags", i), v[11:8], vecs[i].ef);
            check($sformatf("row%0d_acc", i), bus.acc_value, vecs[i].ea);
        end

        // Back-to-back dependent accumulator ops (acc holds 0x08 beforehand).
        drive(OP_PASSB, 8'h00, 8'h05, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_ready0", bus.in_ready, 1);
        @(posedge clk);
        #1;
        drive(OP_ADD, 8'hEE, 8'h03, 1'b1, 1'b1);
        @(negedge clk);
        check("b2b_ready1", bus.in_ready, 1);
        @(posedge clk);
        #1;
        idle();
        get(v, "b2b_first");
        check("b2b_first_result", v[7:0], 8'h05);
        get(v, "b2b_second");
        check("b2b_second_result", v[7:0], 8'h08);
        check("b2b_second_flags", v[11:8], 4'b0000);
        check("b2b_acc", bus.acc_value, 8'h08);

        // Output stall: 4 cycles of out_ready low with 3 ops offered.
        sop = '{OP_ADD, OP_XOR, OP_OR};
        sa  = '{8'h01, 8'h0F, 8'h00};
        sb  = '{8'h01, 8'hFF, 8'h00};
        ser = '{8'h02, 8'hF0, 8'h00};
        sef = '{4'b0000, 4'b1000, 4'b0100};
        bus.out_ready = 1'b0;
        idx = 0;
        drive(sop[0], sa[0], sb[0], 1'b0, 1'b0);
        for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
            if (cyc == 4) bus.out_ready = 1'b1;
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            if (cyc == 3) begin
                check("stall_accepted", idx, 2);
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_no_output", out_q.size(), 0);
            end
            @(posedge clk);
            #1;
            if (hs) idx++;
            if (idx < 3) drive(sop[idx], sa[idx], sb[idx], 1'b0, 1'b0);
            else idle();
        end
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get(v, $sformatf("stall%0d", k));
            check($sformatf("stall%0d_result", k), v[7:0], ser[k]);
            check($sformatf("stall%0d_flags", k), v[11:8], sef[k]);
        end

        // Reset with two operations in flight.
        drive(OP_PASSB, 8'h00, 8'h77, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        check("pre_rst_out_valid", bus.out_valid, 1);
        check("pre_rst_acc", bus.acc_value, 8'h77);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_acc", bus.acc_value, 0);
        check("mid_rst_flags", bus.out_flags, 0);
        check("mid_rst_result", bus.out_result, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_nothing_emitted", out_q.size(), 0);
        check("post_rst_out_valid", bus.out_valid, 0);

        lat_test("post_rst_latency", OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual run still active required finished");
        $fatal(1, "timeout");
    end

endmodule
